alarm_controller: RTL and testbench
===================================

ALARM_CONTROLLER -- requirements
Module: alarm_controller

Interface
REQ-001 Parameter RING_CYCLES, default 20: clock cycles the alarm rings before auto-off.
REQ-002 Parameter SNOOZE_CYCLES, default 30: clock cycles spent in snooze before re-ringing.
REQ-003 Parameter BUZZ_DIV, default 4: cycles per buzzer half-period.
REQ-004 Port clk  in  1  the single clock, rising edge.
REQ-005 Port rst  in  1  reset, asynchronous, active-low.
REQ-006 Port seconds  in  4  current seconds digit from the upstream counter, 0-9.
REQ-007 Port minutes  in  3  current minutes digit from the upstream counter, 0-5.
REQ-008 Port set_alarm  in  1  load request for the alarm time, one-cycle pulse.
REQ-009 Port set_seconds  in  4  alarm seconds value, sampled with set_alarm.
REQ-010 Port set_minutes  in  3  alarm minutes value, sampled with set_alarm.
REQ-011 Port arm  in  1  arm request.
REQ-012 Port snooze  in  1  snooze request.
REQ-013 Port stop  in  1  disarm/silence request.
REQ-014 Port alarm_seconds  out  4  stored alarm seconds.
REQ-015 Port alarm_minutes  out  3  stored alarm minutes.
REQ-016 Port state  out  2  FSM state: IDLE=0, ARMED=1, RINGING=2, SNOOZE=3.
REQ-017 Port ringing  out  1  high exactly while state is RINGING.
REQ-018 Port buzzer  out  1  square wave while ringing, 0 otherwise.

Function
REQ-019 set_alarm SHALL load alarm registers only in IDLE or ARMED and only if set_seconds<=9 and set_minutes<=5; otherwise registers hold.
REQ-020 match SHALL be seconds==alarm_seconds AND minutes==alarm_minutes; match_d SHALL register match every cycle in all states.
REQ-021 match_rise = match AND NOT match_d; alarm SHALL fire only on match_rise, so arming while already matching does not fire until the next match.
REQ-022 IDLE: arm -> ARMED; all other requests ignored.
REQ-023 ARMED: stop -> IDLE; else match_rise -> RINGING with ring counter loaded RING_CYCLES-1; arm ignored.
REQ-024 RINGING priority stop > snooze > timeout: stop -> IDLE; snooze -> SNOOZE with snooze counter loaded SNOOZE_CYCLES-1; ring counter==0 -> ARMED; else counter decrements.
REQ-025 SNOOZE: stop -> IDLE; snooze counter==0 -> RINGING with ring counter reloaded; else decrement; snooze and arm ignored.
REQ-026 Latency: ringing SHALL rise at the clock edge following the first cycle match is true (1 cycle).
REQ-027 Ring duration SHALL be exactly RING_CYCLES cycles; snooze duration exactly SNOOZE_CYCLES cycles.
REQ-028 buzzer SHALL be 1 on the first RINGING cycle and toggle every BUZZ_DIV cycles; divider SHALL restart on every RINGING entry and force 0 outside RINGING.
REQ-029 Counters SHALL be sized $clog2 of their parameter (min 1 bit) and never wrap below 0.

Reset
REQ-030 While rst=0: state=IDLE, alarm_seconds=0, alarm_minutes=0, match_d=0, counters=0, ringing=0, buzzer=0.
REQ-031 Reset asserted mid-RINGING or mid-SNOOZE SHALL clear outputs immediately, without waiting for clk.

Structure
REQ-032 Shared package alarm_pkg SHALL hold the state typedef/encoding and constants SEC_MAX=9, MIN_MAX=5.
REQ-033 Buzzer divider SHALL be one sub-module, buzzer_div (enable, restart, BUZZ_DIV parameter, tone output).

Verification
REQ-034 Load 0:05, arm, drive time 0:04 then 0:05 -> ringing=1 on the next edge, state=2, buzzer=1.
REQ-035 Ring untouched -> ringing low after exactly 20 cycles, state=1; buzzer toggles every 4 cycles meanwhile.
REQ-036 Snooze at ring cycle 3 -> state=3 for 30 cycles, then ringing=1 again for 20 cycles.
REQ-037 stop and snooze asserted together in RINGING -> state=0, ringing=0, buzzer=0 next edge.
REQ-038 set_alarm with set_seconds=12 -> alarm_seconds unchanged; arm while time already equals alarm -> no ring until next match.
REQ-039 rst pulled low mid-SNOOZE between clk edges -> all outputs 0, state=0 immediately.

Source files
------------

// File: rtl/alarm_pkg.sv
// Shared definitions for the alarm controller.
// Holds the state encoding (visible on the state output), the legal
// ranges for the alarm time digits, and a helper that sizes down-counters.
package alarm_pkg;

    typedef logic [1:0] state_t;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_ARMED   = 2'd1;
    localparam logic [1:0] ST_RINGING = 2'd2;
    localparam logic [1:0] ST_SNOOZE  = 2'd3;

    localparam logic [3:0] SEC_MAX = 4'd9;
    localparam logic [2:0] MIN_MAX = 3'd5;

    // Counter width for a down-counter that starts at n-1; never below 1 bit.
    function automatic int cnt_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/buzzer_div.sv
// Buzzer tone divider.
// Ports:
//   clk      - clock, rising edge
//   rst      - asynchronous active-low reset
//   enable   - tone runs while high, forced low otherwise
//   restart  - pulse on the edge that enters ringing; tone starts high
//   tone     - square wave, BUZZ_DIV cycles per half-period
module buzzer_div
    import alarm_pkg::*;
#(
    parameter int BUZZ_DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic enable,
    input  logic restart,
    output logic tone
);

    localparam int DW = cnt_width(BUZZ_DIV);

    logic [DW-1:0] div_cnt;
    logic          tone_q;

    // restart wins over enable: it arrives on the edge where enable is still low.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            div_cnt <= '0;
            tone_q  <= 1'b0;
        end else if (restart) begin
            div_cnt <= DW'(BUZZ_DIV - 1);
            tone_q  <= 1'b1;
        end else if (!enable) begin
            div_cnt <= '0;
            tone_q  <= 1'b0;
        end else if (div_cnt == '0) begin
            div_cnt <= DW'(BUZZ_DIV - 1);
            tone_q  <= ~tone_q;
        end else begin
            div_cnt <= div_cnt - 1'b1;
        end
    end

    assign tone = tone_q & enable;

endmodule

// File: rtl/alarm_controller.sv
// Alarm clock controller: stores an alarm time, fires on the rising edge of
// a time match, rings for a fixed time, supports snooze and stop.
// Ports:
//   clk, rst                  - clock (rising edge), async active-low reset
//   seconds, minutes          - current time digits from the upstream counter
//   set_alarm                 - load pulse for set_seconds / set_minutes
//   arm, snooze, stop         - user requests
//   alarm_seconds/minutes     - stored alarm time
//   state                     - FSM state (see table)
//   ringing, buzzer           - ringing flag and buzzer square wave
//
// state   | meaning
// IDLE    | disarmed, alarm time may be loaded
// ARMED   | waiting for a new time match, alarm time may be loaded
// RINGING | buzzer active, ring counter running
// SNOOZE  | silenced, snooze counter running before re-ringing
module alarm_controller
    import alarm_pkg::*;
#(
    parameter int RING_CYCLES   = 20,
    parameter int SNOOZE_CYCLES = 30,
    parameter int BUZZ_DIV      = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] seconds,
    input  logic [2:0] minutes,
    input  logic       set_alarm,
    input  logic [3:0] set_seconds,
    input  logic [2:0] set_minutes,
    input  logic       arm,
    input  logic       snooze,
    input  logic       stop,
    output logic [3:0] alarm_seconds,
    output logic [2:0] alarm_minutes,
    output logic [1:0] state,
    output logic       ringing,
    output logic       buzzer
);

    localparam int RW = cnt_width(RING_CYCLES);
    localparam int SW = cnt_width(SNOOZE_CYCLES);

    state_t        state_q, state_nxt;
    logic [RW-1:0] ring_cnt;
    logic [SW-1:0] snz_cnt;
    logic          match, match_d, match_rise;
    logic          ring_load, snz_load;

    assign match      = (seconds == alarm_seconds) && (minutes == alarm_minutes);
    assign match_rise = match && !match_d;

    always_comb begin
        state_nxt = state_q;
        ring_load = 1'b0;
        snz_load  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (arm) state_nxt = ST_ARMED;
            end
            ST_ARMED: begin
                if (stop) begin
                    state_nxt = ST_IDLE;
                end else if (match_rise) begin
                    state_nxt = ST_RINGING;
                    ring_load = 1'b1;
                end
            end
            ST_RINGING: begin
                if (stop) begin
                    state_nxt = ST_IDLE;
                end else if (snooze) begin
                    state_nxt = ST_SNOOZE;
                    snz_load  = 1'b1;
                end else if (ring_cnt == '0) begin
                    state_nxt = ST_ARMED;
                end
            end
            ST_SNOOZE: begin
                if (stop) begin
                    state_nxt = ST_IDLE;
                end else if (snz_cnt == '0) begin
                    state_nxt = ST_RINGING;
                    ring_load = 1'b1;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= ST_IDLE;
            match_d       <= 1'b0;
            ring_cnt      <= '0;
            snz_cnt       <= '0;
            alarm_seconds <= '0;
            alarm_minutes <= '0;
        end else begin
            state_q <= state_nxt;
            match_d <= match;

            if (ring_load)
                ring_cnt <= RW'(RING_CYCLES - 1);
            else if (state_q == ST_RINGING && ring_cnt != '0)
                ring_cnt <= ring_cnt - 1'b1;

            if (snz_load)
                snz_cnt <= SW'(SNOOZE_CYCLES - 1);
            else if (state_q == ST_SNOOZE && snz_cnt != '0)
                snz_cnt <= snz_cnt - 1'b1;

            if (set_alarm && (state_q == ST_IDLE || state_q == ST_ARMED) &&
                set_seconds <= SEC_MAX && set_minutes <= MIN_MAX) begin
                alarm_seconds <= set_seconds;
                alarm_minutes <= set_minutes;
            end
        end
    end

    assign state   = state_q;
    assign ringing = (state_q == ST_RINGING);

    buzzer_div #(
        .BUZZ_DIV (BUZZ_DIV)
    ) u_buzzer_div (
        .clk     (clk),
        .rst     (rst),
        .enable  (ringing),
        .restart (ring_load),
        .tone    (buzzer)
    );

endmodule

// File: tb/tb_alarm_controller.sv
// Directed bench for alarm_controller with default parameters
// (ring 20 cycles, snooze 30 cycles, buzzer half-period 4 cycles).
module tb_alarm_controller;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] seconds;
    logic [2:0] minutes;
    logic       set_alarm;
    logic [3:0] set_seconds;
    logic [2:0] set_minutes;
    logic       arm, snooze, stop;
    logic [3:0] alarm_seconds;
    logic [2:0] alarm_minutes;
    logic [1:0] state;
    logic       ringing, buzzer;

    int checks = 0;
    int errors = 0;

    alarm_controller dut (
        .clk           (clk),
        .rst           (rst),
        .seconds       (seconds),
        .minutes       (minutes),
        .set_alarm     (set_alarm),
        .set_seconds   (set_seconds),
        .set_minutes   (set_minutes),
        .arm           (arm),
        .snooze        (snooze),
        .stop          (stop),
        .alarm_seconds (alarm_seconds),
        .alarm_minutes (alarm_minutes),
        .state         (state),
        .ringing       (ringing),
        .buzzer        (buzzer)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        if (obs != exp) begin
            errors++;
            $display("FAIL %s observed %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic tick_n(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    // Break and re-make the 0:05 match so the next edge sees a match rise.
    task automatic retrigger();
        seconds = 4'd6;
        tick();
        seconds = 4'd5;
        tick();
    endtask

    initial begin
        rst = 1'b0;
        seconds = 4'd0; minutes = 3'd0;
        set_alarm = 1'b0; set_seconds = 4'd0; set_minutes = 3'd0;
        arm = 1'b0; snooze = 1'b0; stop = 1'b0;

        #2;
        check("rst_state", state, 0);
        check("rst_ringing", ringing, 0);
        check("rst_buzzer", buzzer, 0);
        check("rst_alarm_sec", alarm_seconds, 0);
        check("rst_alarm_min", alarm_minutes, 0);
        tick_n(2);
        rst = 1'b1;

        // Load 0:05
        set_seconds = 4'd5; set_minutes = 3'd0; set_alarm = 1'b1;
        tick();
        set_alarm = 1'b0;
        check("load_sec", alarm_seconds, 5);
        check("load_min", alarm_minutes, 0);

        // Out-of-range loads are rejected
        set_seconds = 4'd12; set_alarm = 1'b1;
        tick();
        set_alarm = 1'b0;
        check("bad_sec_hold", alarm_seconds, 5);
        set_seconds = 4'd3; set_minutes = 3'd6; set_alarm = 1'b1;
        tick();
        set_alarm = 1'b0;
        check("bad_min_hold_sec", alarm_seconds, 5);
        check("bad_min_hold_min", alarm_minutes, 0);

        // Arm at 0:04, then time reaches 0:05
        seconds = 4'd4; minutes = 3'd0; arm = 1'b1;
        tick();
        arm = 1'b0;
        check("armed_state", state, 1);
        check("armed_ringing", ringing, 0);
        seconds = 4'd5;
        tick();
        check("fire_ringing", ringing, 1);
        check("fire_state", state, 2);
        check("fire_buzzer", buzzer, 1);

        // Untouched ring: 20 cycles, buzzer toggles every 4
        for (int i = 1; i < 20; i++) begin
            tick();
            check("ring_hold", ringing, 1);
            check("ring_buzz", buzzer, ((i / 4) % 2 == 0) ? 1 : 0);
        end
        tick();
        check("timeout_ringing", ringing, 0);
        check("timeout_state", state, 1);
        check("timeout_buzzer", buzzer, 0);
        tick();
        check("no_refire_same_match", state, 1);

        // Snooze at ring cycle 3
        retrigger();
        check("ring2_state", state, 2);
        tick_n(3);
        snooze = 1'b1;
        tick();
        snooze = 1'b0;
        check("snooze_state", state, 3);
        check("snooze_ringing", ringing, 0);
        check("snooze_buzzer", buzzer, 0);
        for (int i = 1; i < 30; i++) begin
            tick();
            check("snooze_hold", state, 3);
        end
        tick();
        check("rering_state", state, 2);
        check("rering_buzzer", buzzer, 1);
        for (int i = 1; i < 20; i++) begin
            tick();
            check("rering_hold", state, 2);
        end
        tick();
        check("rering_timeout", state, 1);

        // stop and snooze together: stop wins
        retrigger();
        check("ring3_state", state, 2);
        stop = 1'b1; snooze = 1'b1;
        tick();
        stop = 1'b0; snooze = 1'b0;
        check("stop_state", state, 0);
        check("stop_ringing", ringing, 0);
        check("stop_buzzer", buzzer, 0);

        // Arm while already matching: no ring until the next match
        arm = 1'b1;
        tick();
        arm = 1'b0;
        check("arm_matching_state", state, 1);
        tick_n(3);
        check("arm_matching_quiet", state, 1);
        retrigger();
        check("next_match_state", state, 2);
        check("next_match_ringing", ringing, 1);

        // Async reset mid-snooze, between clock edges
        snooze = 1'b1;
        tick();
        snooze = 1'b0;
        check("snooze2_state", state, 3);
        tick_n(5);
        #3;
        rst = 1'b0;
        #1;
        check("async_rst_state", state, 0);
        check("async_rst_ringing", ringing, 0);
        check("async_rst_buzzer", buzzer, 0);
        check("async_rst_alarm_sec", alarm_seconds, 0);
        check("async_rst_alarm_min", alarm_minutes, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
